// File: rtl/vit_frame_scheduler.sv
// Descriptor FIFO plus launch/run/complete sequencer for viterbi_core, one frame per job.
// Optional watchdog abort of hung frames is compiled in with VIT_SCHED_WDOG_EN.
module vit_frame_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4,
    parameter int WDOG_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_an_i,
    input  logic                       rst_sync_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [ID_W-1:0]            job_id_i,
    input  logic [1:0]                 job_register_num_i,
    input  logic [2:0]                 job_valid_polys_i,
    input  logic                       job_tail_biting_i,
    input  logic [11:0]                job_infobit_len_i,
    input  logic [12:0]                job_decode_len_i,
    input  logic [11:0]                job_src_addr_i,
    input  logic [11:0]                job_dst_addr_i,
    input  logic [WDOG_W-1:0]          wdog_limit_i,
    output logic                       frame_start_o,
    output logic [1:0]                 register_num_o,
    output logic [2:0]                 valid_polynomials_o,
    output logic                       tail_biting_en_o,
    output logic [11:0]                infobit_length_o,
    output logic [12:0]                decoding_length_o,
    output logic [11:0]                src_start_addr_o,
    output logic [11:0]                dst_start_addr_o,
    output logic                       core_abort_o,
    input  logic                       frame_done_i,
    input  logic                       busy_i,
    output logic                       done_valid_o,
    output logic [ID_W-1:0]            done_id_o,
    output logic [1:0]                 done_err_o,
    output logic [$clog2(DEPTH):0]     pending_o,
    output logic                       sched_busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      reg_num;
        logic [2:0]      polys;
        logic            tail;
        logic [11:0]     info;
        logic [12:0]     dec;
        logic [11:0]     src;
        logic [11:0]     dst;
    } job_t;

`ifdef VIT_SCHED_WDOG_EN
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE, S_REJECT, S_ABORT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE, S_REJECT} state_t;
`endif

    state_t        state_q, state_d;
    job_t          mem [DEPTH];
    job_t          job_in, head, cfg_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, head_bad;

    assign job_in = '{id: job_id_i, reg_num: job_register_num_i, polys: job_valid_polys_i,
                      tail: job_tail_biting_i, info: job_infobit_len_i, dec: job_decode_len_i,
                      src: job_src_addr_i, dst: job_dst_addr_i};

    // Ready comes only from registered occupancy, so a full FIFO refuses even on a pop cycle.
    assign job_ready_o = (count_q != FULL);
    assign push        = job_valid_i && job_ready_o;
    assign head        = mem[rptr_q];
    assign head_bad    = (head.info == '0) || ({1'b0, head.info} > head.dec);

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= job_in;
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (rst_sync_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
        end else if (rst_sync_i) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) cfg_q <= head;
        end
    end

`ifdef VIT_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_hit;
    logic              unused_in;

    assign unused_in = busy_i;
    // Hit on the RUN cycle that completes the limit-th count; limit 0 never hits.
    assign wdog_hit  = (wdog_limit_i != '0) && (WDOG_W'(wdog_cnt_q + 1'b1) == wdog_limit_i);

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i)                wdog_cnt_q <= '0;
        else if (rst_sync_i)          wdog_cnt_q <= '0;
        else if (state_q == S_LAUNCH) wdog_cnt_q <= '0;
        else if (state_q == S_RUN)    wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
`else
    logic unused_in;
    assign unused_in = busy_i ^ (^wdog_limit_i);
`endif

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        frame_start_o = 1'b0;
        done_valid_o  = 1'b0;
        done_err_o    = 2'd0;
        core_abort_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = head_bad ? S_REJECT : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                frame_start_o = 1'b1;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (frame_done_i) state_d = S_DONE;
`ifdef VIT_SCHED_WDOG_EN
                else if (wdog_hit) state_d = S_ABORT;
`endif
            end
            S_DONE: begin
                done_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            S_REJECT: begin
                done_valid_o = 1'b1;
                done_err_o   = 2'd1;
                state_d      = S_IDLE;
            end
`ifdef VIT_SCHED_WDOG_EN
            S_ABORT: begin
                done_valid_o = 1'b1;
                done_err_o   = 2'd2;
                core_abort_o = 1'b1;
                state_d      = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign register_num_o      = cfg_q.reg_num;
    assign valid_polynomials_o = cfg_q.polys;
    assign tail_biting_en_o    = cfg_q.tail;
    assign infobit_length_o    = cfg_q.info;
    assign decoding_length_o   = cfg_q.dec;
    assign src_start_addr_o    = cfg_q.src;
    assign dst_start_addr_o    = cfg_q.dst;
    assign done_id_o           = cfg_q.id;
    assign pending_o           = count_q;
    assign sched_busy_o        = (state_q != S_IDLE);

endmodule
